// File: rtl/mgt_01_f_reg_file_ctx_pkg.sv
// rtl/mgt_01_f_reg_file_ctx_pkg.sv - shared constants and context FSM state type
package mgt_01_f_reg_file_ctx_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic [1:0] {
    CTX_IDLE    = 2'd0,
    CTX_SAVE    = 2'd1,
    CTX_RESTORE = 2'd2,
    CTX_DONE    = 2'd3
  } ctx_state_e;

endpackage

// File: rtl/mgt_01_dirty_pri_enc.sv
// rtl/mgt_01_dirty_pri_enc.sv - lowest-set-bit finder over the dirty vector
module mgt_01_dirty_pri_enc
  import mgt_01_f_reg_file_ctx_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  vec,
  output logic              found,
  output logic [ADDR_W-1:0] index
);

  // Scan downward so the lowest set bit is the last one to overwrite index.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        index = ADDR_W'(i);
      end
    end
  end

endmodule

// File: rtl/mgt_01_f_reg_file_ctx.sv
// rtl/mgt_01_f_reg_file_ctx.sv - multi-port register file with dirty tracking and context save/restore
module mgt_01_f_reg_file_ctx
  import mgt_01_f_reg_file_ctx_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  parameter int  N_RD   = 3,
  parameter bit  BYPASS = 1'b1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        clk_en_i,
  input  logic                        we_i,
  input  logic [ADDR_W-1:0]           w_addr_i,
  input  logic [DATA_W-1:0]           w_data_i,
  input  logic [N_RD-1:0][ADDR_W-1:0] r_addr_i,
  output logic [N_RD-1:0][DATA_W-1:0] r_data_o,
  input  logic                        save_start_i,
  input  logic                        restore_start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        save_valid_o,
  input  logic                        save_ready_i,
  output logic [ADDR_W-1:0]           save_addr_o,
  output logic [DATA_W-1:0]           save_data_o,
  input  logic                        rest_valid_i,
  output logic                        rest_ready_o,
  input  logic [DATA_W-1:0]           rest_data_i,
  output logic [DEPTH-1:0]            dirty_o
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  dirty;
  ctx_state_e        state;
  logic [ADDR_W-1:0] ptr;
  logic              dirty_found;
  logic [ADDR_W-1:0] dirty_idx;
  logic              core_we;
  logic              save_fire;
  logic              rest_fire;

  mgt_01_dirty_pri_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dirty_pri_enc (
    .vec   (dirty),
    .found (dirty_found),
    .index (dirty_idx)
  );

  // Core writes are only honoured while idle; busy-time writes vanish.
  assign core_we      = clk_en_i & we_i & (state == CTX_IDLE);
  assign save_valid_o = clk_en_i & (state == CTX_SAVE) & dirty_found;
  assign save_addr_o  = dirty_idx;
  assign save_data_o  = regs[dirty_idx];
  assign rest_ready_o = clk_en_i & (state == CTX_RESTORE);
  assign save_fire    = save_valid_o & save_ready_i;
  assign rest_fire    = rest_ready_o & rest_valid_i;
  assign busy_o       = (state != CTX_IDLE);
  assign done_o       = (state == CTX_DONE);
  assign dirty_o      = dirty;

  // Restore data never forwards; core_we is low outside IDLE so the bypass cannot fire then.
  always_comb begin
    for (int p = 0; p < N_RD; p++) begin
      if (BYPASS && core_we && (r_addr_i[p] == w_addr_i)) begin
        r_data_o[p] = w_data_i;
      end else begin
        r_data_o[p] = regs[r_addr_i[p]];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (core_we) begin
      regs[w_addr_i] <= w_data_i;
    end else if (rest_fire) begin
      regs[ptr] <= rest_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dirty <= '0;
    end else begin
      if (core_we) begin
        dirty[w_addr_i] <= 1'b1;
      end
      if (save_fire) begin
        dirty[dirty_idx] <= 1'b0;
      end
      if (rest_fire) begin
        dirty[ptr] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= CTX_IDLE;
      ptr   <= '0;
    end else if (clk_en_i) begin
      case (state)
        CTX_IDLE: begin
          if (save_start_i) begin
            state <= CTX_SAVE;
          end else if (restore_start_i) begin
            state <= CTX_RESTORE;
          end
        end
        CTX_SAVE: begin
          if (!dirty_found) begin
            state <= CTX_DONE;
          end
        end
        CTX_RESTORE: begin
          if (rest_fire) begin
            ptr <= ptr + 1'b1;
            if (ptr == ADDR_W'(DEPTH - 1)) begin
              state <= CTX_DONE;
            end
          end
        end
        CTX_DONE: begin
          state <= CTX_IDLE;
        end
        default: begin
          state <= CTX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mgt_01_f_reg_file_ctx.sv
// tb/tb_mgt_01_f_reg_file_ctx.sv - self-checking bench for mgt_01_f_reg_file_ctx
module tb_mgt_01_f_reg_file_ctx;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic                   clk           = 1'b0;
  logic                   rst_n         = 1'b0;
  logic                   clk_en        = 1'b0;
  logic                   we            = 1'b0;
  logic [AW-1:0]          w_addr        = '0;
  logic [DW-1:0]          w_data        = '0;
  logic [NRD-1:0][AW-1:0] r_addr        = '0;
  logic [NRD-1:0][DW-1:0] r_data;
  logic                   save_start    = 1'b0;
  logic                   restore_start = 1'b0;
  logic                   busy;
  logic                   done;
  logic                   save_valid;
  logic                   save_ready    = 1'b0;
  logic [AW-1:0]          save_addr;
  logic [DW-1:0]          save_data;
  logic                   rest_valid    = 1'b0;
  logic                   rest_ready;
  logic [DW-1:0]          rest_data     = '0;
  logic [DEPTH-1:0]       dirty;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]    mreg [DEPTH];
  logic [DEPTH-1:0] mdirty;

  typedef struct {
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [AW-1:0]    raddr;
    logic [DW-1:0]    exp_rdata;
    logic [DEPTH-1:0] exp_dirty;
  } vec_t;

  vec_t tbl [8];

  mgt_01_f_reg_file_ctx #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .N_RD   (NRD),
    .BYPASS (1'b1)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .clk_en_i        (clk_en),
    .we_i            (we),
    .w_addr_i        (w_addr),
    .w_data_i        (w_data),
    .r_addr_i        (r_addr),
    .r_data_o        (r_data),
    .save_start_i    (save_start),
    .restore_start_i (restore_start),
    .busy_o          (busy),
    .done_o          (done),
    .save_valid_o    (save_valid),
    .save_ready_i    (save_ready),
    .save_addr_o     (save_addr),
    .save_data_o     (save_data),
    .rest_valid_i    (rest_valid),
    .rest_ready_o    (rest_ready),
    .rest_data_i     (rest_data),
    .dirty_o         (dirty)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mreg[i] = '0;
    mdirty = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; we = 1'b0; save_start = 1'b0; restore_start = 1'b0;
    save_ready = 1'b0; rest_valid = 1'b0; clk_en = 1'b1;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_save_valid", save_valid, 0);
    chk("rst_rest_ready", rest_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; w_addr = a; w_data = d;
    tick();
    we = 1'b0;
    mreg[a]   = d;
    mdirty[a] = 1'b1;
  endtask

  // Walks every address through read port 0 while the block sits idle.
  task automatic read_all_chk(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      r_addr[0] = AW'(i);
      #1;
      chk($sformatf("%s_reg%0d", tag, i), r_data[0], mreg[i]);
    end
    tick();
  endtask

  initial begin
    int               nbeat;
    int               done_cnt;
    int               kpat;
    int               gap;
    int               e;
    int               q_exp [$];
    logic             fin;
    logic             hold_pending;
    logic [AW-1:0]    hold_addr;
    logic [DW-1:0]    hold_data;
    logic [DW-1:0]    exp_rd;
    logic [3:0]       pat;

    tbl[0] = '{1'b1, 5'd5,  32'h3F80_0000, 5'd5,  32'h3F80_0000, 32'h0000_0020};
    tbl[1] = '{1'b0, 5'd5,  32'h0000_0000, 5'd5,  32'h3F80_0000, 32'h0000_0020};
    tbl[2] = '{1'b1, 5'd7,  32'h1234_5678, 5'd5,  32'h3F80_0000, 32'h0000_00A0};
    tbl[3] = '{1'b0, 5'd7,  32'hFFFF_FFFF, 5'd7,  32'h1234_5678, 32'h0000_00A0};
    tbl[4] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 32'h0000_00A1};
    tbl[5] = '{1'b0, 5'd1,  32'h0000_0000, 5'd1,  32'h0000_0000, 32'h0000_00A1};
    tbl[6] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 32'hA5A5_A5A5, 32'h8000_00A1};
    tbl[7] = '{1'b0, 5'd31, 32'h0000_0000, 5'd31, 32'hA5A5_A5A5, 32'h8000_00A1};

    do_reset();

    // Directed core write/read vectors, all read ports on the same address.
    for (int k = 0; k < 8; k++) begin
      we = tbl[k].we; w_addr = tbl[k].waddr; w_data = tbl[k].wdata;
      for (int p = 0; p < NRD; p++) r_addr[p] = tbl[k].raddr;
      #3;
      for (int p = 0; p < NRD; p++) chk($sformatf("tbl%0d_rd%0d", k, p), r_data[p], tbl[k].exp_rdata);
      tick();
      chk($sformatf("tbl%0d_dirty", k), dirty, tbl[k].exp_dirty);
    end
    we = 1'b0;

    do_reset();
    read_all_chk("rst");

    // Randomized core traffic against the array model.
    for (int n = 0; n < 150; n++) begin
      we     = 1'($urandom_range(0, 1));
      w_addr = AW'($urandom_range(0, DEPTH - 1));
      w_data = $urandom();
      for (int p = 0; p < NRD; p++)
        r_addr[p] = ($urandom_range(0, 3) == 0) ? w_addr : AW'($urandom_range(0, DEPTH - 1));
      #3;
      for (int p = 0; p < NRD; p++) begin
        exp_rd = (we && (r_addr[p] == w_addr)) ? w_data : mreg[r_addr[p]];
        chk($sformatf("rnd%0d_rd%0d", n, p), r_data[p], exp_rd);
      end
      tick();
      if (we) begin
        mreg[w_addr]   = w_data;
        mdirty[w_addr] = 1'b1;
      end
      chk($sformatf("rnd%0d_dirty", n), dirty, mdirty);
    end
    we = 1'b0;

    // Save of regs 2, 9, 31 with ready pattern 1,0,1,1 and core writes attempted while busy.
    do_reset();
    write_reg(5'd2,  32'h2222_0002);
    write_reg(5'd9,  32'h9999_0009);
    write_reg(5'd31, 32'h3131_0031);
    q_exp.delete();
    for (int i = 0; i < DEPTH; i++) if (mdirty[i]) q_exp.push_back(i);
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    pat = 4'b1101;
    kpat = 0; done_cnt = 0; fin = 1'b0; hold_pending = 1'b0;
    for (int c = 0; c < 30 && !fin; c++) begin
      save_ready = (kpat < 4) ? pat[kpat] : 1'b1;
      kpat++;
      we = busy; w_addr = 5'd4; w_data = 32'hBAD0_0BAD; r_addr[0] = 5'd4;
      #3;
      if (busy) chk("save_we_rd", r_data[0], mreg[4]);
      if (hold_pending) begin
        chk("save_hold_valid", save_valid, 1);
        chk("save_hold_addr", save_addr, hold_addr);
        chk("save_hold_data", save_data, hold_data);
        hold_pending = 1'b0;
      end
      if (save_valid && save_ready) begin
        if (q_exp.size() == 0) begin
          chk("save_extra_beat", save_addr, 64'hFFFF);
        end else begin
          e = q_exp.pop_front();
          chk("save_beat_addr", save_addr, e);
          chk("save_beat_data", save_data, mreg[e]);
          mdirty[e] = 1'b0;
        end
      end else if (save_valid) begin
        hold_pending = 1'b1;
        hold_addr    = save_addr;
        hold_data    = save_data;
      end
      if (done) done_cnt++;
      if (!busy) fin = 1'b1;
      tick();
    end
    we = 1'b0; save_ready = 1'b0;
    chk("save_finished", fin, 1);
    chk("save_beats_left", q_exp.size(), 0);
    chk("save_done_cnt", done_cnt, 1);
    chk("save_dirty", dirty, 0);
    read_all_chk("after_save");

    // Save with nothing dirty: done two cycles after the request.
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    #3;
    chk("empty_c1_busy", busy, 1);
    chk("empty_c1_valid", save_valid, 0);
    chk("empty_c1_done", done, 0);
    tick();
    #3;
    chk("empty_c2_done", done, 1);
    chk("empty_c2_valid", save_valid, 0);
    tick();
    chk("empty_c3_busy", busy, 0);
    chk("empty_c3_done", done, 0);

    // Full restore with random valid gaps and a clock-enable stall mid-stream.
    write_reg(5'd3,  32'h0303_0303);
    write_reg(5'd20, 32'h2020_2020);
    restore_start = 1'b1;
    tick();
    restore_start = 1'b0;
    nbeat = 0; done_cnt = 0; fin = 1'b0; gap = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (nbeat == 16 && gap < 3) begin
        clk_en = 1'b0;
        gap++;
      end else begin
        clk_en = 1'b1;
      end
      rest_valid = (!clk_en) ? 1'b1 : ($urandom_range(0, 2) != 0);
      rest_data  = 32'h100 + DW'(nbeat);
      r_addr[0]  = AW'(nbeat);
      #3;
      if (busy && !done) chk("rest_rd_nobypass", r_data[0], mreg[nbeat % DEPTH]);
      if (!clk_en) chk("rest_ready_gated", rest_ready, 0);
      if (rest_valid && rest_ready) begin
        mreg[nbeat]   = rest_data;
        mdirty[nbeat] = 1'b0;
        nbeat++;
      end
      if (done) done_cnt++;
      if (!busy) fin = 1'b1;
      tick();
    end
    clk_en = 1'b1; rest_valid = 1'b0;
    chk("rest_finished", fin, 1);
    chk("rest_stall_seen", gap, 3);
    chk("rest_nbeat", nbeat, 32);
    chk("rest_done_cnt", done_cnt, 1);
    chk("rest_dirty", dirty, 0);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("rest_model%0d", i), mreg[i], 32'h100 + i);
    read_all_chk("after_rest");

    // Reset pulsed after restore beat 10: operation aborts with no done pulse.
    write_reg(5'd7, 32'h7777_7777);
    restore_start = 1'b1;
    tick();
    restore_start = 1'b0;
    nbeat = 0;
    for (int c = 0; c < 100 && nbeat < 10; c++) begin
      rest_valid = 1'b1;
      rest_data  = 32'hABC0 + DW'(nbeat);
      #3;
      if (rest_valid && rest_ready) nbeat++;
      tick();
    end
    chk("abort_nbeat", nbeat, 10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy_async", busy, 0);
    chk("abort_ready_async", rest_ready, 0);
    chk("abort_dirty_async", dirty, 0);
    #1;
    rst_n = 1'b1;
    rest_valid = 1'b0;
    model_reset();
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      #3;
      if (done) done_cnt++;
      chk("abort_idle", busy, 0);
    end
    tick();
    chk("abort_done_cnt", done_cnt, 0);
    read_all_chk("abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
